bram_fifo_ctrl: RTL

Flow-control wrapper that turns the raw BRAM circular buffer (`bram_fifo`) into a valid/ready streaming FIFO. It tracks occupancy, gates `wren`/`rden`, and absorbs the one-cycle BRAM read latency with a 2-entry output stage, so the consumer sees zero-bubble throughput. It sits between an upstream producer (AXI-stream-like) and the ESTU accumulator datapath.

---
 rtl/bram_fifo_ctrl_pkg.sv | 21 ++
 rtl/bram_fifo.sv | 65 ++++++
 rtl/bram_fifo_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared definitions for the BRAM FIFO controller slice: default sizing
// constants and the clogb2 width helper used to size counters and ports.
package bram_fifo_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 25;
    localparam int unsigned DEFAULT_DEPTH      = 717;

    // Number of bits needed to represent 'value' (clogb2(6)=3, clogb2(8)=4),
    // so a counter sized with it can hold 'value' itself.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bram_fifo.sv
// Raw BRAM circular buffer: write/read address counters that wrap at DEPTH-1,
// a registered (one-cycle latency) read port and an optional counter clear.
// The clear input only takes effect when CLEAR_EN is set; the controller sets
// it when built with FIFO_FLUSH_EN.
module bram_fifo
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter bit          CLEAR_EN   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic                  rden,
    input  logic                  clear_counter,
    input  logic [DATA_WIDTH-1:0] DI,
    output logic [DATA_WIDTH-1:0] DO
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? clogb2(DEPTH - 1) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_cnt;
    logic [ADDR_W-1:0]     rd_cnt;
    logic                  clr;

    assign clr = CLEAR_EN & clear_counter;

    // Storage array write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wr_cnt] <= DI;
        end
    end

    // Circular write/read pointers, wrapping DEPTH-1 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (clr) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wren) begin
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
            end
            if (rden) begin
                rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
            end
        end
    end

    // Registered read data, valid the cycle after rden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DO <= '0;
        end else if (rden) begin
            DO <= mem[rd_cnt];
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready wrapper around bram_fifo: tracks BRAM occupancy, gates
// wren/rden and hides the one-cycle read latency behind a 2-entry output
// stage (out_reg + skid_reg) for bubble-free streaming.
// Optional synchronous flush port and BRAM counter clear: FIFO_FLUSH_EN.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned LVL_W      = clogb2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [LVL_W-1:0]      level
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [LVL_W-1:0]      bram_cnt;
    logic [LVL_W-1:0]      bram_cnt_nxt;
    logic [1:0]            occ_out;
    logic [1:0]            occ_after;
    logic [1:0]            occ_nxt;
    logic                  inflight;
    logic                  wr;
    logic                  rden;
    logic                  pop;
    logic                  clr;
    logic                  ram_rst;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [DATA_WIDTH-1:0] skid_reg;
    logic [DATA_WIDTH-1:0] ram_do;

`ifdef FIFO_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign ram_rst   = ~rst;
    assign pop       = m_valid & m_ready;
    assign wr        = s_valid & s_ready & ~clr;
    // Only issue a read if its data is guaranteed a slot in the output stage.
    assign rden      = ~clr && (bram_cnt != '0) &&
                       (({1'b0, occ_out} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign occ_after = occ_out - {1'b0, pop};
    assign occ_nxt   = occ_after + {1'b0, inflight};

    assign m_valid = (occ_out != 2'd0);
    assign m_data  = out_reg;
    assign level   = bram_cnt + LVL_W'(inflight) + LVL_W'(occ_out);

    // Next BRAM occupancy: write and read issue cancel each other.
    always_comb begin
        bram_cnt_nxt = bram_cnt;
        if (clr) begin
            bram_cnt_nxt = '0;
        end else if (wr && !rden) begin
            bram_cnt_nxt = bram_cnt + 1'b1;
        end else if (!wr && rden) begin
            bram_cnt_nxt = bram_cnt - 1'b1;
        end
    end

    // Occupancy, read-in-flight and registered ready; s_ready looks at the
    // next count so the cycle that fills the BRAM already drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bram_cnt <= '0;
            occ_out  <= '0;
            inflight <= 1'b0;
            s_ready  <= 1'b0;
        end else begin
            bram_cnt <= bram_cnt_nxt;
            occ_out  <= clr ? 2'd0 : occ_nxt;
            inflight <= rden;
            s_ready  <= (bram_cnt_nxt < DEPTH_L);
        end
    end

    // Output stage: skid shifts forward on pop, returning data fills the
    // first free slot (out_reg when it empties this cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else if (!clr) begin
            if (pop && occ_out == 2'd2) begin
                out_reg <= skid_reg;
            end
            if (inflight) begin
                if (occ_after == 2'd0) begin
                    out_reg <= ram_do;
                end else begin
                    skid_reg <= ram_do;
                end
            end
        end
    end

    bram_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
`ifdef FIFO_FLUSH_EN
        .CLEAR_EN   (1'b1)
`else
        .CLEAR_EN   (1'b0)
`endif
    ) u_fifo_ram (
        .clk           (clk),
        .rst           (ram_rst),
        .wren          (wr),
        .rden          (rden),
        .clear_counter (clr),
        .DI            (s_data),
        .DO            (ram_do)
    );

endmodule
